// File: rtl/hawk_att_lkup_responder_if.sv
// Lookup and memory-port bundle for hawk_att_lkup_responder.
// slave  : responder side (accepts lookups, drives memory requests)
// master : environment side (ctrl unit issuing lookups, memory answering)
interface hawk_att_lkup_responder_if #(
    parameter int HPPA_W = 28,
    parameter int WAY_W  = 28
);
    logic              lkup_lookup;
    logic [HPPA_W-1:0] lkup_hppa;
    logic              pgrd_mngr_ready;
    logic              trnsl_allow_access;
    logic [WAY_W-1:0]  trnsl_ppa;
    logic              tol_tbl_update;
    logic [WAY_W-1:0]  tol_way;
    logic              tbl_update_done;
    logic              oom;
    logic              mem_rd_req;
    logic [63:0]       mem_rd_addr;
    logic              mem_rd_valid;
    logic [63:0]       mem_rd_data;
    logic              mem_wr_req;
    logic [63:0]       mem_wr_addr;
    logic [63:0]       mem_wr_data;
    logic              mem_wr_ack;

    modport slave (
        input  lkup_lookup, lkup_hppa, mem_rd_valid, mem_rd_data, mem_wr_ack,
        output pgrd_mngr_ready, trnsl_allow_access, trnsl_ppa, tol_tbl_update,
               tol_way, tbl_update_done, oom, mem_rd_req, mem_rd_addr,
               mem_wr_req, mem_wr_addr, mem_wr_data
    );

    modport master (
        output lkup_lookup, lkup_hppa, mem_rd_valid, mem_rd_data, mem_wr_ack,
        input  pgrd_mngr_ready, trnsl_allow_access, trnsl_ppa, tol_tbl_update,
               tol_way, tbl_update_done, oom, mem_rd_req, mem_rd_addr,
               mem_wr_req, mem_wr_addr, mem_wr_data
    );
endinterface

// File: rtl/hawk_att_lkup_responder.sv
// ATT lookup responder: reads the ATT entry for a host page, answers hits
// directly, and on a miss pops the free-list head and writes the new entry.
// One lookup at a time; the requester must drop lookup before the next one.
// Optional build macro HAWK_LKUP_STATS_EN adds saturating hit/alloc counters.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | ready, waiting for a lookup
// ATT_RD    | reading ATT entry of the latched hppa
// HIT       | entry allocated, ppa presented with allow_access
// LST_RD    | reading free-list node at head
// ATT_WR    | writing newly allocated entry back to the ATT
// OOM       | free list empty, sticky oom raised, no translation
// WAIT_DROP | result held until the requester drops lookup
module hawk_att_lkup_responder #(
    parameter int                HPPA_W    = 28,
    parameter int                WAY_W     = 28,
    parameter logic [63:0]       ATT_BASE  = 64'h0,
    parameter logic [63:0]       LST_BASE  = 64'h100000,
    parameter logic [HPPA_W-1:0] FREE_HEAD = HPPA_W'(1)
) (
    input  logic clk_i,
    input  logic rst_ni,
    hawk_att_lkup_responder_if.slave bus
`ifdef HAWK_LKUP_STATS_EN
    ,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] alloc_cnt_o
`endif
);

    typedef enum logic [2:0] {
        IDLE, ATT_RD, HIT, LST_RD, ATT_WR, OOM, WAIT_DROP
    } state_t;

    state_t            state;
    logic [HPPA_W-1:0] hppa_q;
    logic [HPPA_W-1:0] head;
    logic [WAY_W-1:0]  way_q;

    // 8-byte entries: index is zero-extended then shifted by 3
    function automatic logic [63:0] entry_addr(input logic [63:0] base,
                                               input logic [HPPA_W-1:0] idx);
        return base + {{(61-HPPA_W){1'b0}}, idx, 3'b000};
    endfunction

    // Lookup sequencer with registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state                  <= IDLE;
            hppa_q                 <= '0;
            head                   <= FREE_HEAD;
            way_q                  <= '0;
            bus.pgrd_mngr_ready    <= 1'b1;
            bus.trnsl_allow_access <= 1'b0;
            bus.trnsl_ppa          <= '0;
            bus.tol_tbl_update     <= 1'b0;
            bus.tol_way            <= '0;
            bus.tbl_update_done    <= 1'b0;
            bus.oom                <= 1'b0;
            bus.mem_rd_req         <= 1'b0;
            bus.mem_rd_addr        <= '0;
            bus.mem_wr_req         <= 1'b0;
            bus.mem_wr_addr        <= '0;
            bus.mem_wr_data        <= '0;
        end else begin
            bus.tbl_update_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.lkup_lookup) begin
                        hppa_q              <= bus.lkup_hppa;
                        bus.pgrd_mngr_ready <= 1'b0;
                        bus.mem_rd_req      <= 1'b1;
                        bus.mem_rd_addr     <= entry_addr(ATT_BASE, bus.lkup_hppa);
                        state               <= ATT_RD;
                    end
                end
                ATT_RD: begin
                    if (bus.mem_rd_valid) begin
                        bus.mem_rd_req <= 1'b0;
                        if (bus.mem_rd_data[1:0] == 2'b10) begin
                            bus.trnsl_ppa          <= bus.mem_rd_data[WAY_W+1:2];
                            bus.trnsl_allow_access <= 1'b1;
                            state                  <= HIT;
                        end else if (head == '0) begin
                            bus.oom <= 1'b1;
                            state   <= OOM;
                        end else begin
                            // read stays requested, now aimed at the list head
                            bus.mem_rd_req  <= 1'b1;
                            bus.mem_rd_addr <= entry_addr(LST_BASE, head);
                            state           <= LST_RD;
                        end
                    end
                end
                LST_RD: begin
                    if (bus.mem_rd_valid) begin
                        bus.mem_rd_req     <= 1'b0;
                        way_q              <= bus.mem_rd_data[WAY_W-1:0];
                        bus.tol_way        <= bus.mem_rd_data[WAY_W-1:0];
                        head               <= bus.mem_rd_data[32+HPPA_W-1:32];
                        bus.tol_tbl_update <= 1'b1;
                        bus.mem_wr_req     <= 1'b1;
                        bus.mem_wr_addr    <= entry_addr(ATT_BASE, hppa_q);
                        bus.mem_wr_data    <= {{(62-WAY_W){1'b0}},
                                               bus.mem_rd_data[WAY_W-1:0], 2'b10};
                        state              <= ATT_WR;
                    end
                end
                ATT_WR: begin
                    if (bus.mem_wr_ack) begin
                        bus.mem_wr_req         <= 1'b0;
                        bus.tol_tbl_update     <= 1'b0;
                        bus.tbl_update_done    <= 1'b1;
                        bus.trnsl_ppa          <= way_q;
                        bus.trnsl_allow_access <= 1'b1;
                        state                  <= WAIT_DROP;
                    end
                end
                HIT, OOM, WAIT_DROP: begin
                    if (!bus.lkup_lookup) begin
                        bus.trnsl_allow_access <= 1'b0;
                        bus.pgrd_mngr_ready    <= 1'b1;
                        state                  <= IDLE;
                    end else begin
                        state <= WAIT_DROP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef HAWK_LKUP_STATS_EN
    logic hit_evt;
    logic alloc_evt;

    assign hit_evt   = (state == ATT_RD) && bus.mem_rd_valid &&
                       (bus.mem_rd_data[1:0] == 2'b10);
    assign alloc_evt = (state == ATT_WR) && bus.mem_wr_ack;

    // Saturating hit / allocation counters
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hit_cnt_o   <= '0;
            alloc_cnt_o <= '0;
        end else begin
            if (hit_evt && (hit_cnt_o != 32'hFFFF_FFFF))
                hit_cnt_o <= hit_cnt_o + 32'd1;
            if (alloc_evt && (alloc_cnt_o != 32'hFFFF_FFFF))
                alloc_cnt_o <= alloc_cnt_o + 32'd1;
        end
    end
`endif

endmodule
